// File: rtl/quesadilla_pkg.sv
// Shared types and constants for the instruction fetch path.
package quesadilla_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam int PC_STEP = 4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle: push side (in_*) and pop side (out_*).
interface fetch_buffer_if;
   import quesadilla_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_instr;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_instr;

   // slave is the buffer's view; master is the surrounding pipeline's view
   modport slave (
      input  in_valid, in_pc, in_instr, out_ready,
      output in_ready, out_valid, out_pc, out_instr
   );

   modport master (
      output in_valid, in_pc, in_instr, out_ready,
      input  in_ready, out_valid, out_pc, out_instr
   );

endinterface

// File: rtl/fetch_buffer_ram.sv
// Unreset DEPTH-entry packet store: one synchronous write port, one async read port.
module fetch_buffer_ram
   import quesadilla_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  fetch_pkt_t               i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output fetch_pkt_t               o_rdata
);

   fetch_pkt_t r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch FIFO: in-order {pc, instr} delivery to decode, one-cycle flush.
module fetch_buffer
   import quesadilla_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_flush,
   fetch_buffer_if.slave          bus,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic       w_in_ready;
   logic       w_out_valid;
   logic       w_push;
   logic       w_pop;
   fetch_pkt_t w_wr_pkt;
   fetch_pkt_t w_rd_pkt;

   // ready/valid come only from the registered count, so nothing falls through
   assign w_in_ready  = (r_count != FULL_CNT);
   assign w_out_valid = (r_count != '0);
   assign w_push      = bus.in_valid  & w_in_ready  & ~i_flush;
   assign w_pop       = w_out_valid   & bus.out_ready & ~i_flush;

   assign w_wr_pkt.pc    = bus.in_pc;
   assign w_wr_pkt.instr = bus.in_instr;

   fetch_buffer_ram #(.DEPTH(DEPTH)) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wr_pkt),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_pkt)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      end
   end

   // an empty buffer shows a harmless NOP at pc 0 instead of stale storage
   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_pc    = w_out_valid ? w_rd_pkt.pc    : '0;
   assign bus.out_instr = w_out_valid ? w_rd_pkt.instr : NOP_INSTR;
   assign o_count       = r_count;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: vector table plus hand-written corner sequences.
module tb_fetch_buffer;
   import quesadilla_pkg::*;

   typedef struct {
      logic        rst;
      logic        flush;
      logic        iv;
      logic [31:0] pc;
      logic        ordy;
      logic        e_rdy;
      logic        e_vld;
      logic [2:0]  e_cnt;
      logic [31:0] e_pc;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       flush;
   logic [2:0] count;
   int         n_total;
   int         n_pass;
   vec_t       vq[$];

   fetch_buffer_if bus ();

   fetch_buffer #(.DEPTH(4)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_flush (flush),
      .bus     (bus),
      .o_count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return {16'hC0DE, pc[15:0]};
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
   endtask

   task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] pc, input logic ordy,
                      input logic e_rdy, input logic e_vld, input logic [2:0] e_cnt, input logic [31:0] e_pc);
      vec_t v;
      v.rst = r; v.flush = f; v.iv = iv; v.pc = pc; v.ordy = ordy;
      v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_cnt = e_cnt; v.e_pc = e_pc;
      vq.push_back(v);
   endtask

   task automatic check_outs(input int idx, input logic e_rdy, input logic e_vld, input logic [2:0] e_cnt,
                             input logic [31:0] e_pc);
      chk("in_ready",  idx, 32'(bus.in_ready),  32'(e_rdy));
      chk("out_valid", idx, 32'(bus.out_valid), 32'(e_vld));
      chk("count",     idx, 32'(count),         32'(e_cnt));
      chk("out_pc",    idx, bus.out_pc,         e_pc);
      chk("out_instr", idx, bus.out_instr,      e_vld ? instr_of(e_pc) : NOP_INSTR);
   endtask

   initial begin
      int cyc;
      logic [31:0] pc;
      n_total = 0;
      n_pass  = 0;
      rst = 1'b1; flush = 1'b0;
      bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 1'b0;

      // reset then idle; out_ready while empty must be ignored
      add(1,0,0,0,0, 1,0,0,0);
      for (int i = 0; i < 10; i++) add(0,0,0,0,(i == 5), 1,0,0,0);
      // fill with decode stalled; fifth offer is refused
      add(0,0,1,32'd0, 0, 1,1,1,0);
      add(0,0,1,32'd4, 0, 1,1,2,0);
      add(0,0,1,32'd8, 0, 1,1,3,0);
      add(0,0,1,32'd12,0, 0,1,4,0);
      add(0,0,1,32'd16,0, 0,1,4,0);
      // full: first cycle pops only, then streaming push+pop through wrap
      add(0,0,1,32'd16,1, 1,1,3,4);
      for (int i = 0; i < 9; i++) add(0,0,1,32'd16 + 32'(4*i),1, 1,1,3,32'd8 + 32'(4*i));
      add(0,0,0,0,1, 1,1,2,32'd44);
      add(0,0,0,0,1, 1,1,1,32'd48);
      add(0,0,0,0,1, 1,0,0,0);
      // count 2 with push+pop for 6 cycles
      add(0,0,1,32'h100,0, 1,1,1,32'h100);
      add(0,0,1,32'h104,0, 1,1,2,32'h100);
      for (int i = 0; i < 6; i++) add(0,0,1,32'h108 + 32'(4*i),1, 1,1,2,32'h104 + 32'(4*i));
      // count 3, flush swallows the same-cycle push and pop
      add(0,0,1,32'h120,0, 1,1,3,32'h118);
      add(0,1,1,32'h40, 1, 1,0,0,0);
      add(0,0,1,32'h80, 0, 1,1,1,32'h80);
      add(0,0,0,0,1, 1,0,0,0);
      // reset mid-stream, nothing stale afterwards
      add(0,0,1,32'h200,0, 1,1,1,32'h200);
      add(0,0,1,32'h204,0, 1,1,2,32'h200);
      add(0,0,1,32'h208,0, 1,1,3,32'h200);
      add(1,0,1,32'h20C,0, 1,0,0,0);
      add(0,0,0,0,0, 1,0,0,0);
      add(0,0,0,0,1, 1,0,0,0);
      add(0,0,1,32'h300,0, 1,1,1,32'h300);
      add(0,0,0,0,1, 1,0,0,0);
      // reset together with flush
      add(0,0,1,32'h400,0, 1,1,1,32'h400);
      add(1,1,1,32'h404,1, 1,0,0,0);

      foreach (vq[i]) begin
         @(negedge clk);
         rst = vq[i].rst; flush = vq[i].flush;
         bus.in_valid = vq[i].iv; bus.in_pc = vq[i].pc; bus.in_instr = instr_of(vq[i].pc);
         bus.out_ready = vq[i].ordy;
         @(posedge clk); #1;
         check_outs(i, vq[i].e_rdy, vq[i].e_vld, vq[i].e_cnt, vq[i].e_pc);
      end

      // no fall-through: a push into empty is invisible until after the edge
      @(negedge clk);
      rst = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_pc = 32'h500; bus.in_instr = instr_of(32'h500);
      #1;
      chk("no_fallthru_valid", 1000, 32'(bus.out_valid), 32'd0);
      chk("no_fallthru_instr", 1000, bus.out_instr, NOP_INSTR);
      @(posedge clk); #1;
      check_outs(1001, 1'b1, 1'b1, 3'd1, 32'h500);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         bus.in_pc = 32'h500 + 32'(PC_STEP*i); bus.in_instr = instr_of(bus.in_pc);
      end
      @(posedge clk); #1;
      check_outs(1002, 1'b0, 1'b1, 3'd4, 32'h500);

      // stall while full with garbage on the input: head must hold
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.in_pc = $urandom; bus.in_instr = $urandom;
         @(posedge clk); #1;
         check_outs(1003 + i, 1'b0, 1'b1, 3'd4, 32'h500);
      end

      // drain in order, bounded by a cycle budget
      @(negedge clk);
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         pc = 32'h500 + 32'(PC_STEP*i);
         chk("drain_pc",    1010 + i, bus.out_pc,    pc);
         chk("drain_instr", 1010 + i, bus.out_instr, instr_of(pc));
         @(negedge clk);
      end
      cyc = 0;
      while (bus.out_valid !== 1'b0 && cyc < 8) begin
         @(negedge clk);
         cyc++;
      end
      chk("drain_empty_in_budget", 1020, 32'(bus.out_valid), 32'd0);
      chk("drain_count", 1021, 32'(count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
